// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage.
// Owns the PC, keeps a single word request outstanding to instruction memory,
// and loads the IF/ID register. A one-entry skid buffer catches a response
// that arrives while decode is stalled; a kill flag discards a response whose
// request was made before an execute-stage redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] fetch_pc;
    logic        kill;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    logic        ifid_free;
    logic        ifid_load;
    logic [31:0] load_instr;
    logic [31:0] load_pc;
    logic        unused_redirect_lsb;

    // Redirect targets are forced to word alignment; the low bits are dropped.
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign imem_req  = (state == S_REQ) && !redirect_valid;
    assign imem_addr = pc;
    assign ifid_free = !id_valid || !id_stall;

    // Decide whether IF/ID takes a new instruction this cycle, and from where.
    always_comb begin
        ifid_load  = 1'b0;
        load_instr = imem_rdata;
        load_pc    = fetch_pc;
        if (!redirect_valid) begin
            case (state)
                S_WAIT: begin
                    if (imem_rvalid && !kill && ifid_free) begin
                        ifid_load = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!id_stall) begin
                        ifid_load  = 1'b1;
                        load_instr = skid_instr;
                        load_pc    = skid_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Fetch control: PC, request/response sequencing, kill flag and skid buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            fetch_pc   <= '0;
            kill       <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (redirect_valid) begin
            pc         <= {redirect_pc[31:2], 2'b00};
            skid_instr <= '0;
            skid_pc    <= '0;
            // A request already in flight must have its response discarded.
            if (state == S_WAIT && !imem_rvalid) begin
                state <= S_WAIT;
                kill  <= 1'b1;
            end else begin
                state <= S_REQ;
                kill  <= 1'b0;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_gnt) begin
                        fetch_pc <= pc;
                        pc       <= pc + 32'd4;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else if (ifid_free) begin
                            state <= S_REQ;
                        end else begin
                            skid_instr <= imem_rdata;
                            skid_pc    <= fetch_pc;
                            state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!id_stall) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // IF/ID register: flush on redirect, load on delivery, drain when not stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc    <= '0;
            id_pc4   <= 32'd4;
        end else if (redirect_valid) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end else if (ifid_load) begin
            id_valid <= 1'b1;
            id_instr <= load_instr;
            id_pc    <= load_pc;
            id_pc4   <= load_pc + 32'd4;
        end else if (!id_stall) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed, table-driven bench for fetch_stage.
// Each table row gives the inputs for one clock cycle and the outputs expected
// during that cycle (before its rising edge). Hand-written sequences cover
// asynchronous reset in the middle of a transaction.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0  = 32'h0010_0093;
    localparam logic [31:0] W1  = 32'h0050_0093;
    localparam logic [31:0] W2  = 32'h0020_8133;
    localparam logic [31:0] W3  = 32'h0000_A183;
    localparam logic [31:0] W4  = 32'h00C0_0213;
    localparam logic [31:0] W5  = 32'h0100_0293;
    localparam logic [31:0] W6  = 32'h0073_0313;
    localparam int NV = 26;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    int checks;
    int errors;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdv;
        logic [31:0] rdpc;
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        idv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } vec_t;

    vec_t vecs [NV];

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc4         (id_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic req, input logic [31:0] addr,
                                 input logic idv, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic [31:0] pc4);
        check({tag, " imem_req"},  {31'd0, imem_req}, {31'd0, req});
        check({tag, " imem_addr"}, imem_addr, addr);
        check({tag, " id_valid"},  {31'd0, id_valid}, {31'd0, idv});
        check({tag, " id_instr"},  id_instr, instr);
        check({tag, " id_pc"},     id_pc, pc);
        check({tag, " id_pc4"},    id_pc4, pc4);
    endtask

    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rdata,
                         input logic rdv, input logic [31:0] rdpc, input logic stall);
        imem_gnt       = gnt;
        imem_rvalid    = rv;
        imem_rdata     = rdata;
        redirect_valid = rdv;
        redirect_pc    = rdpc;
        id_stall       = stall;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //            gnt  rv    rdata          rdv   rdpc           stl | req  addr           idv   instr pc             pc4
        // zero-wait fetch from reset
        vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, NOP, 32'h0,         32'h4};
        vecs[1]  = '{1'b0, 1'b1, W0,            1'b0, 32'h0,         1'b0, 1'b0, 32'h4,         1'b0, NOP, 32'h0,         32'h4};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h4,         1'b1, W0,  32'h0,         32'h4};
        vecs[3]  = '{1'b0, 1'b1, W1,            1'b0, 32'h0,         1'b0, 1'b0, 32'h8,         1'b0, NOP, 32'h0,         32'h4};
        // stall while W1@4 sits in IF/ID; next response goes to the skid buffer
        vecs[4]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         1'b1, W1,  32'h4,         32'h8};
        vecs[5]  = '{1'b0, 1'b1, W2,            1'b0, 32'h0,         1'b1, 1'b0, 32'hC,         1'b1, W1,  32'h4,         32'h8};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'hC,         1'b1, W1,  32'h4,         32'h8};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'hC,         1'b1, W1,  32'h4,         32'h8};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'hC,         1'b1, W2,  32'h8,         32'hC};
        vecs[9]  = '{1'b0, 1'b1, W3,            1'b0, 32'h0,         1'b0, 1'b0, 32'h10,        1'b0, NOP, 32'h8,         32'hC};
        vecs[10] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h10,        1'b1, W3,  32'hC,         32'h10};
        // redirect to 0x103 while fetch @0x10 is pending; stale word is dropped
        vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h103,       1'b0, 1'b0, 32'h14,        1'b0, NOP, 32'hC,         32'h10};
        vecs[12] = '{1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 32'h0,         1'b0, 1'b0, 32'h100,       1'b0, NOP, 32'hC,         32'h10};
        vecs[13] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h100,       1'b0, NOP, 32'hC,         32'h10};
        vecs[14] = '{1'b0, 1'b1, W4,            1'b0, 32'h0,         1'b0, 1'b0, 32'h104,       1'b0, NOP, 32'hC,         32'h10};
        // redirect together with rvalid under stall; target 0xFFFFFFFC exercises wrap
        vecs[15] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h104,       1'b1, W4,  32'h100,       32'h104};
        vecs[16] = '{1'b0, 1'b1, 32'hBAD00013,  1'b1, 32'hFFFFFFFC,  1'b1, 1'b0, 32'h108,       1'b1, W4,  32'h100,       32'h104};
        vecs[17] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFFFFFC,  1'b0, NOP, 32'h100,       32'h104};
        vecs[18] = '{1'b0, 1'b1, W5,            1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, NOP, 32'h100,       32'h104};
        vecs[19] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1, W5,  32'hFFFFFFFC,  32'h0};
        // redirect in REQ: no request, gnt ignored; then rvalid outside WAIT ignored
        vecs[20] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h42,        1'b0, 1'b0, 32'h0,         1'b0, NOP, 32'hFFFFFFFC,  32'h0};
        vecs[21] = '{1'b0, 1'b1, 32'h0BADBAD3,  1'b0, 32'h0,         1'b0, 1'b1, 32'h40,        1'b0, NOP, 32'hFFFFFFFC,  32'h0};
        // slower memory: rvalid two cycles after gnt
        vecs[22] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h40,        1'b0, NOP, 32'hFFFFFFFC,  32'h0};
        vecs[23] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h44,        1'b0, NOP, 32'hFFFFFFFC,  32'h0};
        vecs[24] = '{1'b0, 1'b1, W6,            1'b0, 32'h0,         1'b0, 1'b0, 32'h44,        1'b0, NOP, 32'hFFFFFFFC,  32'h0};
        vecs[25] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h44,        1'b1, W6,  32'h40,        32'h44};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        check_outputs("reset", 1'b1, 32'h0, 1'b0, NOP, 32'h0, 32'h4);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].rdv, vecs[i].rdpc, vecs[i].stall);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].idv,
                          vecs[i].instr, vecs[i].pc, vecs[i].pc4);
            @(negedge clk);
        end

        // Fetch @0x44 delivered, then a stalled fetch @0x48 left pending in WAIT.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h0010_0113, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #1;
        check_outputs("pre_reset", 1'b0, 32'h4C, 1'b1, 32'h0010_0113, 32'h44, 32'h48);
        // Reset asserted mid-cycle: outputs must change with no clock edge.
        rst_n = 1'b0;
        #1;
        check_outputs("async_reset", 1'b1, 32'h0, 1'b0, NOP, 32'h0, 32'h4);
        // Release with a late rvalid from the aborted fetch; it must be ignored.
        drive(1'b0, 1'b1, 32'hDEAD_0013, 1'b0, 32'h0, 1'b0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        check_outputs("post_reset", 1'b1, 32'h0, 1'b0, NOP, 32'h0, 32'h4);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h0000_0513, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        check_outputs("refetch", 1'b1, 32'h4, 1'b1, 32'h0000_0513, 32'h0, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
